// File: rtl/mold_msg_len_cnt.sv
// ============================================================================
// Module   : mold_msg_len_cnt
// Brief    : MoldUDP64 per-message byte counter; emits message bytes per beat.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mold_msg_len_cnt #(
  parameter int KEEP_W    = 8,
  parameter int LEN_W     = 4,
  parameter int MSG_LEN_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 valid_i,
  input  logic                 start_i,
  input  logic [MSG_LEN_W-1:0] msg_len_i,
  output logic [LEN_W-1:0]     len_o,
  output logic                 len_v_o,
  output logic                 last_o,
  output logic                 busy_o,
  output logic                 err_o
);

  localparam logic [MSG_LEN_W-1:0] C_KEEP = MSG_LEN_W'(KEEP_W);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [MSG_LEN_W-1:0]   rem_q, rem_d;
  logic [LEN_W-1:0]       len_q, len_d;
  logic                   len_v_q, len_v_d;
  logic                   last_q, last_d;
  logic                   err_q, err_d;

  logic [MSG_LEN_W-1:0]   src;
  logic [MSG_LEN_W-1:0]   bytes;
  logic [MSG_LEN_W-1:0]   rem_next;

  // A start beat always sources its byte count from the new length, even in BUSY.
  always_comb begin
    src      = start_i ? msg_len_i : rem_q;
    bytes    = (src >= C_KEEP) ? C_KEEP : src;
    rem_next = src - bytes;
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    len_d   = len_q;
    len_v_d = 1'b0;
    last_d  = 1'b0;
    err_d   = 1'b0;

    if (valid_i) begin
      if (start_i) begin
        if (state_q == BUSY) begin
          err_d = 1'b1;
        end
        if (msg_len_i == '0) begin
          err_d   = 1'b1;
          state_d = IDLE;
          rem_d   = '0;
        end else begin
          len_d   = LEN_W'(bytes);
          len_v_d = 1'b1;
          if (rem_next == '0) begin
            last_d  = 1'b1;
            state_d = IDLE;
            rem_d   = '0;
          end else begin
            state_d = BUSY;
            rem_d   = rem_next;
          end
        end
      end else if (state_q == BUSY) begin
        len_d   = LEN_W'(bytes);
        len_v_d = 1'b1;
        rem_d   = rem_next;
        if (rem_next == '0) begin
          last_d  = 1'b1;
          state_d = IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      rem_q   <= '0;
      len_q   <= '0;
      len_v_q <= 1'b0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      len_q   <= len_d;
      len_v_q <= len_v_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  assign len_o   = len_q;
  assign len_v_o = len_v_q;
  assign last_o  = last_q;
  assign err_o   = err_q;
  assign busy_o  = (state_q == BUSY);

endmodule

`default_nettype wire

// File: tb/tb_mold_msg_len_cnt.sv
// ============================================================================
// Module   : tb_mold_msg_len_cnt
// Brief    : Vector table, corner sequences and randomized model check.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mold_msg_len_cnt;

  logic        clk;
  logic        reset;
  logic        valid_i;
  logic        start_i;
  logic [15:0] msg_len_i;
  logic [3:0]  len_o;
  logic        len_v_o;
  logic        last_o;
  logic        busy_o;
  logic        err_o;

  int checks = 0;
  int errors = 0;

  mold_msg_len_cnt #(
    .KEEP_W(8), .LEN_W(4), .MSG_LEN_W(16)
  ) dut (
    .clk(clk), .reset(reset), .valid_i(valid_i), .start_i(start_i),
    .msg_len_i(msg_len_i), .len_o(len_o), .len_v_o(len_v_o),
    .last_o(last_o), .busy_o(busy_o), .err_o(err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic        s;
    logic [15:0] l;
    logic        e_lv;
    logic [3:0]  e_len;
    logic        e_last;
    logic        e_busy;
    logic        e_err;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic v, input logic s, input logic [15:0] l);
    @(negedge clk);
    valid_i   = v;
    start_i   = s;
    msg_len_i = l;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic lv, input logic [3:0] ln,
                         input logic la, input logic bz, input logic er);
    chk({tag, ".len_v"}, int'(len_v_o), int'(lv));
    if (lv) chk({tag, ".len"}, int'(len_o), int'(ln));
    chk({tag, ".last"}, int'(last_o), int'(la));
    chk({tag, ".busy"}, int'(busy_o), int'(bz));
    chk({tag, ".err"}, int'(err_o), int'(er));
  endtask

  vec_t vecs[$];
  int   q[$];

  initial begin
    valid_i = 0; start_i = 0; msg_len_i = 0;
    reset = 1'b1;
    #1;
    chk_all("reset", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    chk("reset.len", int'(len_o), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    //       v  s  len   lv len last busy err
    vecs.push_back('{1, 1, 16'd20, 1, 8, 0, 1, 0});
    vecs.push_back('{1, 0, 16'd0,  1, 8, 0, 1, 0});
    vecs.push_back('{1, 0, 16'd0,  1, 4, 1, 0, 0});
    vecs.push_back('{1, 1, 16'd5,  1, 5, 1, 0, 0});
    vecs.push_back('{1, 1, 16'd8,  1, 8, 1, 0, 0});
    vecs.push_back('{1, 1, 16'd17, 1, 8, 0, 1, 0});
    vecs.push_back('{0, 0, 16'd0,  0, 0, 0, 1, 0});
    vecs.push_back('{1, 0, 16'd0,  1, 8, 0, 1, 0});
    vecs.push_back('{0, 1, 16'd99, 0, 0, 0, 1, 0});
    vecs.push_back('{1, 0, 16'd0,  1, 1, 1, 0, 0});
    vecs.push_back('{1, 0, 16'd0,  0, 0, 0, 0, 0});
    vecs.push_back('{1, 1, 16'd0,  0, 0, 0, 0, 1});
    vecs.push_back('{0, 0, 16'd0,  0, 0, 0, 0, 0});
    vecs.push_back('{1, 1, 16'd24, 1, 8, 0, 1, 0});
    vecs.push_back('{1, 1, 16'd3,  1, 3, 1, 0, 1});
    vecs.push_back('{1, 1, 16'd9,  1, 8, 0, 1, 0});
    vecs.push_back('{1, 1, 16'd0,  0, 0, 0, 0, 1});
    vecs.push_back('{1, 0, 16'd0,  0, 0, 0, 0, 0});

    foreach (vecs[i]) begin
      step(vecs[i].v, vecs[i].s, vecs[i].l);
      chk_all($sformatf("vec%0d", i), vecs[i].e_lv, vecs[i].e_len,
              vecs[i].e_last, vecs[i].e_busy, vecs[i].e_err);
    end

    // Reset while BUSY with 12 bytes outstanding
    step(1, 1, 16'd20);
    chk("rst_busy.pre", int'(busy_o), 1);
    @(negedge clk);
    valid_i = 0; start_i = 0;
    reset = 1'b1;
    #1;
    chk_all("rst_busy", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    chk("rst_busy.len", int'(len_o), 0);
    @(negedge clk);
    reset = 1'b0;
    step(1, 0, 16'd0);
    chk_all("rst_busy.after", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);

    // Maximum length message: 8191 full beats then 7 bytes
    step(1, 1, 16'hFFFF);
    chk_all("max.first", 1'b1, 4'd8, 1'b0, 1'b1, 1'b0);
    for (int b = 1; b < 8191; b++) begin
      step(1, 0, 16'd0);
      chk_all("max.mid", 1'b1, 4'd8, 1'b0, 1'b1, 1'b0);
    end
    step(1, 0, 16'd0);
    chk_all("max.final", 1'b1, 4'd7, 1'b1, 1'b0, 1'b0);

    // Randomized run against a queue-of-beats reference
    q.delete();
    for (int n = 0; n < 3000; n++) begin
      logic        v, s;
      logic [15:0] l;
      logic        e_lv, e_last, e_err;
      int          e_len;
      v = ($urandom_range(0, 9) < 7);
      s = ($urandom_range(0, 9) < 2);
      l = ($urandom_range(0, 19) == 0) ? 16'd0 : 16'($urandom_range(1, 45));
      e_lv = 0; e_last = 0; e_err = 0; e_len = 0;
      if (v && s) begin
        e_err = (q.size() > 0) || (l == 0);
        q.delete();
        for (int k = 0; k < int'(l) / 8; k++) q.push_back(8);
        if (int'(l) % 8 != 0) q.push_back(int'(l) % 8);
      end
      if (v && q.size() > 0) begin
        e_len  = q.pop_front();
        e_lv   = 1;
        e_last = (q.size() == 0);
      end
      step(v, s, l);
      chk_all($sformatf("rnd%0d", n), e_lv, 4'(e_len), e_last, q.size() > 0, e_err);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
